// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master serial bus: FSM states, owner
// encoding, address width and slave-select codes carried in addr[13:12].
package bus_pkg;

    localparam int ADDR_W = 14;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        SHIFT,
        WAIT_SLV,
        HOLD
    } state_t;

    typedef enum logic {
        OWN_M1,
        OWN_M2
    } owner_t;

    localparam logic [1:0] SLV_SEL_0 = 2'b00;
    localparam logic [1:0] SLV_SEL_1 = 2'b01;
    localparam logic [1:0] SLV_SEL_2 = 2'b10;

    function automatic logic [1:0] slv_sel(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:ADDR_W-2];
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bus_arbiter_addr_if.sv
// Master-side request/serial lines and arbiter-side grant/address signals.
// master drives requests, tx and slave responses; slave is the arbiter.
interface bus_arbiter_addr_if;

    logic                         m1_breq;
    logic                         m2_breq;
    logic                         m1_tx;
    logic                         m2_tx;
    logic                         m1_grant;
    logic                         m2_grant;
    logic                         m1;
    logic                         m2;
    logic [bus_pkg::ADDR_W-1:0]   addr;
    logic                         addr_rdy;
    logic                         slv_ready;
    logic                         split;
    logic                         err;

    modport master (
        output m1_breq, m2_breq, m1_tx, m2_tx, slv_ready, split,
        input  m1_grant, m2_grant, m1, m2, addr, addr_rdy, err
    );

    modport slave (
        input  m1_breq, m2_breq, m1_tx, m2_tx, slv_ready, split,
        output m1_grant, m2_grant, m1, m2, addr, addr_rdy, err
    );

endinterface

// File: rtl/serial_addr_rx.sv
// MSB-first shift register with bit counter: load clears, en shifts one bit,
// done stays high from the cycle after the W-th bit until the next load.
module serial_addr_rx #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load_i,
    input  logic         en_i,
    input  logic         din_i,
    output logic [W-1:0] data_o,
    output logic         done_o
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  sh_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (en_i && !done_o) begin
            sh_q  <= {sh_q[W-2:0], din_i};
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign done_o = (cnt_q == CW'(W));
    assign data_o = sh_q;

endmodule

// File: rtl/bus_arbiter_addr.sv
// Front stage of the two-master bus: arbitrates M1/M2, deserialises the owner's
// address frame, holds the bus through the data phase, releases on split/abort/timeout.
module bus_arbiter_addr #(
    parameter int ADDR_W   = bus_pkg::ADDR_W,
    parameter bit RR_EN    = 1'b1,
    parameter int START_TO = 8,
    parameter int SLV_TO   = 16,
    parameter int HOLD_CYC = 11
) (
    input logic               clk,
    input logic               rstn,
    bus_arbiter_addr_if.slave bus
);

    import bus_pkg::*;

    localparam int CNT_W = $clog2(max3(START_TO, SLV_TO, HOLD_CYC) + 1);

    state_t            state_q;
    owner_t            owner_q;
    owner_t            owner_d;
    owner_t            last_owner_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic              m1_grant_q;
    logic              m2_grant_q;
    logic              addr_rdy_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;

    logic              owner_tx;
    logic              owner_req;
    logic              rx_load;
    logic              rx_done;
    logic [ADDR_W-1:0] rx_data;

    // Only the owner's lines are ever looked at; the other master's tx is ignored.
    assign owner_tx  = (owner_q == OWN_M1) ? bus.m1_tx   : bus.m2_tx;
    assign owner_req = (owner_q == OWN_M1) ? bus.m1_breq : bus.m2_breq;
    assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign rx_load   = (state_q == WAIT_START) && owner_req && !owner_tx;

    always_comb begin
        owner_d = OWN_M1;
        if (bus.m1_breq && bus.m2_breq) begin
            owner_d = (RR_EN && last_owner_q == OWN_M1) ? OWN_M2 : OWN_M1;
        end else if (bus.m2_breq) begin
            owner_d = OWN_M2;
        end
    end

    serial_addr_rx #(.W(ADDR_W)) u_rx (
        .clk    (clk),
        .rstn   (rstn),
        .load_i (rx_load),
        .en_i   (state_q == SHIFT),
        .din_i  (owner_tx),
        .data_o (rx_data),
        .done_o (rx_done)
    );

    // Grants are only raised from IDLE and every drop returns to IDLE, so there is
    // always at least one cycle with both grants low between owners.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            owner_q      <= OWN_M1;
            last_owner_q <= OWN_M2;
            cnt_q        <= '0;
            m1_grant_q   <= 1'b0;
            m2_grant_q   <= 1'b0;
            addr_rdy_q   <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
        end else begin
            addr_rdy_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.m1_breq || bus.m2_breq) begin
                        owner_q    <= owner_d;
                        m1_grant_q <= (owner_d == OWN_M1);
                        m2_grant_q <= (owner_d == OWN_M2);
                        cnt_q      <= '0;
                        state_q    <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    if (!owner_req) begin
                        m1_grant_q <= 1'b0;
                        m2_grant_q <= 1'b0;
                        state_q    <= IDLE;
                    end else if (!owner_tx) begin
                        state_q <= SHIFT;
                    end else if (cnt_q == CNT_W'(START_TO - 1)) begin
                        err_q      <= 1'b1;
                        m1_grant_q <= 1'b0;
                        m2_grant_q <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                SHIFT: begin
                    if (!owner_req) begin
                        m1_grant_q <= 1'b0;
                        m2_grant_q <= 1'b0;
                        state_q    <= IDLE;
                    end else if (rx_done) begin
                        addr_q     <= rx_data;
                        addr_rdy_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= WAIT_SLV;
                    end
                end
                WAIT_SLV: begin
                    if (bus.split) begin
                        m1_grant_q   <= 1'b0;
                        m2_grant_q   <= 1'b0;
                        last_owner_q <= owner_q;
                        state_q      <= IDLE;
                    end else if (bus.slv_ready) begin
                        cnt_q   <= '0;
                        state_q <= HOLD;
                    end else if (cnt_q == CNT_W'(SLV_TO - 1)) begin
                        err_q      <= 1'b1;
                        m1_grant_q <= 1'b0;
                        m2_grant_q <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                HOLD: begin
                    if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                        m1_grant_q   <= 1'b0;
                        m2_grant_q   <= 1'b0;
                        last_owner_q <= owner_q;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    m1_grant_q <= 1'b0;
                    m2_grant_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign bus.m1_grant = m1_grant_q;
    assign bus.m2_grant = m2_grant_q;
    assign bus.m1       = m1_grant_q;
    assign bus.m2       = m2_grant_q;
    assign bus.addr     = addr_q;
    assign bus.addr_rdy = addr_rdy_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_bus_arbiter_addr.sv
// Directed bench for bus_arbiter_addr: a round-robin instance (a) and a
// fixed-priority instance (b) share stimulus; captured addresses go through a scoreboard.
module tb_bus_arbiter_addr;

    logic clk = 1'b0;
    logic rstn;
    logic m1_breq, m2_breq, m1_tx, m2_tx, slv_ready, split;

    int n_chk  = 0;
    int n_fail = 0;
    int err_a  = 0;
    logic rdy_prev = 1'b0;
    logic [14:0] sb[$];

    bus_arbiter_addr_if bus_a ();
    bus_arbiter_addr_if bus_b ();

    always #5 clk = ~clk;

    assign bus_a.m1_breq   = m1_breq;
    assign bus_a.m2_breq   = m2_breq;
    assign bus_a.m1_tx     = m1_tx;
    assign bus_a.m2_tx     = m2_tx;
    assign bus_a.slv_ready = slv_ready;
    assign bus_a.split     = split;
    assign bus_b.m1_breq   = m1_breq;
    assign bus_b.m2_breq   = m2_breq;
    assign bus_b.m1_tx     = m1_tx;
    assign bus_b.m2_tx     = m2_tx;
    assign bus_b.slv_ready = slv_ready;
    assign bus_b.split     = split;

    bus_arbiter_addr #(.RR_EN(1'b1)) dut_a (.clk(clk), .rstn(rstn), .bus(bus_a));
    bus_arbiter_addr #(.RR_EN(1'b0)) dut_b (.clk(clk), .rstn(rstn), .bus(bus_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_tx(input bit use_m2, input logic v);
        if (use_m2) m2_tx = v;
        else        m1_tx = v;
    endtask

    // Start bit now, then nbits of a MSB first, one per cycle; line returns high.
    task automatic send_frame(input bit use_m2, input logic [13:0] a, input int nbits);
        if (nbits == 14) sb.push_back({use_m2, a});
        drive_tx(use_m2, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            tick();
            drive_tx(use_m2, a[13-i]);
        end
        tick();
        drive_tx(use_m2, 1'b1);
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            rdy_prev <= 1'b0;
        end else begin
            chk("one_hot", 32'(bus_a.m1_grant & bus_a.m2_grant), 32'(0));
            if (bus_a.addr_rdy) begin
                chk("rdy_single_pulse", 32'(rdy_prev), 32'(0));
                chk("sb_nonempty", 32'(sb.size() > 0), 32'(1));
                if (sb.size() > 0)
                    chk("sb_owner_addr", 32'({bus_a.m2_grant, bus_a.addr}), 32'(sb.pop_front()));
            end
            if (bus_a.err) err_a <= err_a + 1;
            rdy_prev <= bus_a.addr_rdy;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; m1_breq = 1'b0; m2_breq = 1'b0;
        m1_tx = 1'b1; m2_tx = 1'b1; slv_ready = 1'b0; split = 1'b0;
        tick(2);
        chk("rst_a_outs", 32'({bus_a.m1_grant, bus_a.m2_grant, bus_a.m1, bus_a.m2,
                              bus_a.addr_rdy, bus_a.err, bus_a.addr}), 32'(0));
        chk("rst_b_outs", 32'({bus_b.m1_grant, bus_b.m2_grant, bus_b.addr_rdy,
                              bus_b.err, bus_b.addr}), 32'(0));
        rstn = 1'b1;
        tick();

        // Simultaneous requests from reset: both instances pick M1
        m1_breq = 1'b1; m2_breq = 1'b1;
        tick();
        chk("arb1_a", 32'({bus_a.m1_grant, bus_a.m2_grant, bus_a.m1, bus_a.m2}), 32'(4'b1010));
        chk("arb1_b", 32'({bus_b.m1_grant, bus_b.m2_grant}), 32'(2'b10));
        send_frame(1'b0, 14'h2A5C, 14);
        chk("lat_rdy_early", 32'(bus_a.addr_rdy), 32'(0));
        tick();
        chk("lat_rdy_15", 32'(bus_a.addr_rdy), 32'(1));
        chk("lat_m2_grant", 32'(bus_a.m2_grant), 32'(0));
        chk("b_addr", 32'(bus_b.addr), 32'(14'h2A5C));
        split = 1'b1;
        tick();
        split = 1'b0;
        chk("split_drop_a", 32'({bus_a.m1_grant, bus_a.m2_grant}), 32'(0));
        chk("split_drop_b", 32'({bus_b.m1_grant, bus_b.m2_grant}), 32'(0));
        tick();
        chk("arb2_a_rr", 32'({bus_a.m1_grant, bus_a.m2_grant, bus_a.m1, bus_a.m2}), 32'(4'b0101));
        chk("arb2_b_fixed", 32'({bus_b.m1_grant, bus_b.m2_grant}), 32'(2'b10));

        // M2 transaction on instance a; split together with slv_ready
        send_frame(1'b1, 14'h3ABC, 14);
        chk("m2_rdy_early", 32'(bus_a.addr_rdy), 32'(0));
        tick();
        chk("m2_rdy", 32'(bus_a.addr_rdy), 32'(1));
        split = 1'b1; slv_ready = 1'b1;
        tick();
        split = 1'b0; slv_ready = 1'b0;
        chk("split_wins_drop", 32'({bus_a.m1_grant, bus_a.m2_grant}), 32'(0));
        tick();
        chk("arb3_a_rr", 32'({bus_a.m1_grant, bus_a.m2_grant}), 32'(2'b10));
        m2_breq = 1'b0;

        // No start bit: grant held 8 cycles then err and release
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("sto_wait", 32'({bus_a.m1_grant, bus_a.err}), 32'(2'b10));
        end
        tick();
        chk("sto_err", 32'({bus_a.m1_grant, bus_a.err}), 32'(2'b01));
        m1_breq = 1'b0;
        tick();
        chk("sto_after", 32'({bus_a.m1_grant, bus_a.m2_grant, bus_a.err}), 32'(0));

        // Single M1, slv_ready right after addr_rdy, 11-cycle hold
        m1_breq = 1'b1;
        tick();
        chk("hold_grant", 32'({bus_a.m1_grant, bus_a.m2_grant, bus_a.m1, bus_a.m2}), 32'(4'b1010));
        send_frame(1'b0, 14'h0123, 14);
        tick();
        chk("hold_rdy", 32'(bus_a.addr_rdy), 32'(1));
        slv_ready = 1'b1; m1_breq = 1'b0;
        tick();
        slv_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            chk("hold_on", 32'(bus_a.m1_grant), 32'(1));
            tick();
        end
        chk("hold_release", 32'({bus_a.m1_grant, bus_a.m2_grant}), 32'(0));
        chk("hold_no_err", 32'(err_a), 32'(1));

        // No slave response within 16 cycles
        m1_breq = 1'b1;
        tick();
        send_frame(1'b0, 14'h1FFF, 14);
        tick();
        chk("slto_rdy", 32'(bus_a.addr_rdy), 32'(1));
        m1_breq = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("slto_wait", 32'({bus_a.m1_grant, bus_a.err}), 32'(2'b10));
        end
        tick();
        chk("slto_err", 32'({bus_a.m1_grant, bus_a.err}), 32'(2'b01));
        tick();

        // Request dropped mid-frame: quiet abort
        m1_breq = 1'b1;
        tick();
        send_frame(1'b0, 14'h0555, 3);
        m1_breq = 1'b0;
        tick();
        chk("abort_drop", 32'({bus_a.m1_grant, bus_a.m2_grant}), 32'(0));
        tick(16);
        chk("abort_no_err", 32'(err_a), 32'(2));

        // Reset in the middle of SHIFT, then a fresh transaction
        m1_breq = 1'b1;
        tick();
        send_frame(1'b0, 14'h2A5C, 7);
        rstn = 1'b0;
        #1;
        chk("midrst_outs", 32'({bus_a.m1_grant, bus_a.m2_grant, bus_a.addr_rdy, bus_a.addr}), 32'(0));
        tick(2);
        rstn = 1'b1;
        tick();
        chk("post_rst_grant", 32'({bus_a.m1_grant, bus_a.m2_grant}), 32'(2'b10));
        send_frame(1'b0, 14'h3C0F, 14);
        tick();
        chk("post_rst_rdy", 32'(bus_a.addr_rdy), 32'(1));
        slv_ready = 1'b1; m1_breq = 1'b0;
        tick();
        slv_ready = 1'b0;
        tick(12);
        chk("post_rst_release", 32'({bus_a.m1_grant, bus_a.m2_grant}), 32'(0));

        chk("sb_drained", 32'(sb.size()), 32'(0));
        chk("err_total", 32'(err_a), 32'(2));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_addr.md
Name: bus_arbiter_addr

Overview:
- Front stage of the two-master serial bus.
- Arbitrates bus requests from masters M1 and M2 and grants the bus to one of them.
- Deserialises the granted master's 14-bit address frame and presents addr/addr_rdy plus owner flags (m1/m2) to the address decoder downstream.
- Holds ownership through the data phase, then releases. Also releases on split, abort or slave-response timeout.

Parameters:
- ADDR_W, 14, address width. Bits [13:12] select the slave.
- RR_EN, 1, 1 = round-robin on simultaneous requests; 0 = fixed M1 priority.
- START_TO, 8, maximum cycles from grant to the start bit before the grant is revoked.
- SLV_TO, 16, maximum cycles from addr_rdy to slv_ready or split.
- HOLD_CYC, 11, cycles the bus stays owned after slv_ready (covers SLV_GRANTED, DATA_TX and the 9-cycle DATA_RX phase).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous, active-low reset.
- m1_breq  in  1  M1 bus request; level, held until granted.
- m2_breq  in  1  M2 bus request.
- m1_tx  in  1  M1 serial line; idles high.
- m2_tx  in  1  M2 serial line; idles high.
- m1_grant  out  1  M1 owns the bus.
- m2_grant  out  1  M2 owns the bus.
- m1  out  1  owner flag to the decoder, equal to m1_grant.
- m2  out  1  owner flag to the decoder, equal to m2_grant.
- addr  out  ADDR_W  captured address.
- addr_rdy  out  1  one-cycle pulse: addr is valid.
- slv_ready  in  1  from the decoder: slave accepted.
- split  in  1  pulse: the slave split the transaction.
- err  out  1  one-cycle pulse on a start or slave timeout.

Behaviour:

Reset values:
- All outputs 0. addr = 0, state = IDLE, last_owner = M2 (so M1 wins the first tie).
- Reset mid-operation drops the grants at once.

State machine:
- IDLE:
  - If any request is pending, select the owner:
    - Single requester wins.
    - Both requesting: if RR_EN, grant the master other than last_owner; otherwise grant M1.
  - Assert the grant and owner flag on the next edge. Go to WAIT_START. Clear the counter.
- WAIT_START:
  - Sample the owner's tx each cycle.
  - tx == 0 is the start bit: go to SHIFT with bit count 0.
  - Counter reaches START_TO-1 without a start bit: pulse err, drop the grant, go to IDLE.
- SHIFT:
  - Each cycle, shift the owner's tx into addr, MSB first: addr <= {addr[ADDR_W-2:0], tx}.
  - Shifting is done in a shadow register. addr output updates only at the end.
  - After ADDR_W bits, load the output addr, pulse addr_rdy for exactly one cycle and go to WAIT_SLV.
  - Address latency: the first address bit arrives on the cycle after the start bit. addr_rdy rises on the edge after bit ADDR_W-1 is sampled (ADDR_W+1 cycles after the start bit is sampled).
- WAIT_SLV:
  - split == 1: drop the grant, set last_owner = owner, go to IDLE. The master must re-request.
  - Else slv_ready == 1: go to HOLD and clear the counter.
  - Else after SLV_TO cycles: pulse err, drop the grant, go to IDLE.
  - If split and slv_ready arrive in the same cycle, split wins.
- HOLD:
  - Grant stays asserted; tx is passed through by the decoder.
  - After HOLD_CYC cycles: drop the grant, set last_owner, go to IDLE.

Rules in every state:
- Grant one-hot invariant: m1_grant & m2_grant is never 1.
- Owner request deasserted during WAIT_START or SHIFT: abort, drop the grant and go to IDLE. No addr_rdy and no err.
- Requests are ignored outside IDLE.
- A grant is never issued in the same cycle it is dropped. There is at least one IDLE cycle with both grants low between owners.
- Counters are saturating and wide enough for max(START_TO, SLV_TO, HOLD_CYC).
- The non-owner's tx is never sampled.

Decomposition:
- Shared package bus_pkg holds:
  - state enum {IDLE, WAIT_START, SHIFT, WAIT_SLV, HOLD};
  - owner enum {OWN_M1, OWN_M2};
  - ADDR_W;
  - slave-select encodings 2'b00/01/10.
- One sub-module: serial_addr_rx, a shift register plus bit counter with enable, load and done outputs. It is reusable by the slave-side receivers.

Test Plan:
- Single M1 request, start bit, then address 14'h2A5C serial MSB first -> m1_grant=m1=1 the cycle after the request; addr_rdy single pulse with addr=14'h2A5C exactly 15 cycles after the start bit is sampled; m2_grant stays 0.
- Both masters request, back-to-back transactions, RR_EN=1 -> grant order M1, M2, M1; at least one cycle with both grants low between owners. Same test with RR_EN=0 -> M1, M1.
- Address 14'h0123, slv_ready one cycle after addr_rdy -> grant held exactly HOLD_CYC=11 cycles after slv_ready, then released; err stays 0.
- Split pulse in WAIT_SLV, including split together with slv_ready -> grant drops the next cycle with no HOLD phase; a subsequent M2 request is granted.
- No start bit for 8 cycles -> err pulse and grant released. In a separate run, no slv_ready within 16 cycles -> err pulse and release.
- rstn asserted during SHIFT at bit 7 -> grants, addr and addr_rdy immediately 0. After rstn rises, a fresh M1 transaction completes correctly.
